sync_down_counter: RTL and testbench

Loadable synchronous down-counter, the counting-down companion of the existing `sync_counter` up-counter. It counts toward zero and reports reaching zero through three outputs: a zero flag, a combinational borrow output for cascading stages, and a registered one-cycle expiry pulse. It sits in timer and prescaler paths, and in delay and watchdog logic that needs an interval loaded, counted out and flagged.

---
 rtl/sync_down_counter.sv | 58 +++++
 tb/tb_sync_down_counter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// Loadable down-counter with zero flag, borrow-out and expiry pulse.
// Define SYNC_DOWN_COUNTER_AUTORELOAD_EN to reload `count` on underflow.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] A,
  output logic             zero,
  output logic             tc,
  output logic             expired
);

  logic [WIDTH-1:0] r_a;
  logic             r_expired;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_next;
  logic             w_one;

  // Borrow chain: bit i flips when every lower bit is already 0.
  always_comb begin
    w_tog[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_tog[i] = w_tog[i-1] & ~r_a[i-1];
    end
  end

`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
  assign w_next = zero ? count : (r_a ^ w_tog);
`else
  assign w_next = r_a ^ w_tog;
`endif

  assign w_one   = (r_a == WIDTH'(1));
  assign zero    = (r_a == '0);
  assign tc      = en & zero;
  assign A       = r_a;
  assign expired = r_expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a       <= '0;
      r_expired <= 1'b0;
    end else if (load) begin
      r_a       <= count;
      r_expired <= 1'b0;
    end else if (en) begin
      r_a       <= w_next;
      r_expired <= w_one;
    end else begin
      r_expired <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed checks for sync_down_counter (WIDTH=4) and a two-stage cascade.
module tb_sync_down_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] count;
  logic [3:0] A;
  logic       zero;
  logic       tc;
  logic       expired;

  logic       c_en;
  logic       c_load;
  logic [7:0] c_count;
  logic [3:0] lo_a;
  logic [3:0] hi_a;
  logic       lo_zero;
  logic       hi_zero;
  logic       lo_tc;
  logic       hi_tc;
  logic       lo_exp;
  logic       hi_exp;

  int n_tests;
  int n_fail;

  sync_down_counter #(.WIDTH(4)) u_dut (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .count(count), .A(A), .zero(zero), .tc(tc),
    .expired(expired)
  );

  sync_down_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .reset(reset), .en(c_en), .load(c_load),
    .count(c_count[3:0]), .A(lo_a), .zero(lo_zero),
    .tc(lo_tc), .expired(lo_exp)
  );

  sync_down_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .reset(reset), .en(lo_tc), .load(c_load),
    .count(c_count[7:4]), .A(hi_a), .zero(hi_zero),
    .tc(hi_tc), .expired(hi_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b0; load = 1'b1; count = 4'd9;
    reset = 1'b1;
    step();
    load = 1'b0;
    n_tests++;
    if (A !== 4'd9) begin
      n_fail++;
      $display("FAIL rst_preload A=%0d exp=9", A);
    end
    #2;
    reset = 1'b0;
    en = 1'b1;
    #1;
    n_tests++;
    if (A !== 4'd0 || expired !== 1'b0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async A=%0d ex=%b z=%b exp=0/0/1",
               A, expired, zero);
    end
    n_tests++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_tc tc=%b exp=1", tc);
    end
    en = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (A !== 4'd0 || expired !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_release A=%0d ex=%b exp=0/0",
                 A, expired);
      end
    end
  endtask

  task automatic test_countout();
    logic [3:0] exp_a [4];
    exp_a = '{4'd3, 4'd2, 4'd1, 4'd0};
    load = 1'b1; count = 4'd3; en = 1'b0;
    step();
    load = 1'b0;
    n_tests++;
    if (A !== exp_a[0] || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_load A=%0d ex=%b exp=3/0", A, expired);
    end
    en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      n_tests++;
      if (A !== exp_a[i] || expired !== (i == 3) ||
          tc !== (i == 3)) begin
        n_fail++;
        $display("FAIL cnt_seq%0d A=%0d ex=%b tc=%b exp=%0d/%b/%b",
                 i, A, expired, tc, exp_a[i], i == 3, i == 3);
      end
    end
    en = 1'b0;
    step();
    n_tests++;
    if (A !== 4'd0 || expired !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_after A=%0d ex=%b tc=%b exp=0/0/0",
               A, expired, tc);
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; count = 4'd5; en = 1'b0;
    step();
    en = 1'b1; count = 4'd12;
    step();
    n_tests++;
    if (A !== 4'd12 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_prio A=%0d ex=%b exp=12/0", A, expired);
    end
    count = 4'd1; en = 1'b0;
    step();
    count = 4'd0; en = 1'b1;
    step();
    n_tests++;
    if (A !== 4'd0 || zero !== 1'b1 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_zero A=%0d z=%b ex=%b exp=0/1/0",
               A, zero, expired);
    end
    load = 1'b0; en = 1'b0;
    step();
    n_tests++;
    if (expired !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_zero_ex ex=%b exp=0", expired);
    end
  endtask

  task automatic test_hold();
    load = 1'b1; count = 4'd7; en = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (A !== 4'd7 || tc !== 1'b0 || expired !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d A=%0d tc=%b ex=%b exp=7/0/0",
                 i, A, tc, expired);
      end
    end
  endtask

  task automatic test_underflow();
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    logic [3:0] exp_a [9];
    exp_a = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0,
              4'd2, 4'd1, 4'd0, 4'd2};
    load = 1'b1; count = 4'd2; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      n_tests++;
      if (A !== exp_a[i] || tc !== (exp_a[i] == 4'd0)) begin
        n_fail++;
        $display("FAIL reload%0d A=%0d tc=%b exp=%0d/%b",
                 i, A, tc, exp_a[i], exp_a[i] == 4'd0);
      end
    end
`else
    load = 1'b1; count = 4'd0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; count = 4'd6;
    step();
    n_tests++;
    if (A !== 4'd15 || expired !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap A=%0d ex=%b tc=%b exp=15/0/0",
               A, expired, tc);
    end
    step();
    n_tests++;
    if (A !== 4'd14) begin
      n_fail++;
      $display("FAIL wrap_next A=%0d exp=14", A);
    end
`endif
    en = 1'b0;
  endtask

  task automatic test_cascade();
    logic [7:0] exp_v [3];
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    exp_v = '{8'h10, 8'h00, 8'h10};
`else
    exp_v = '{8'h10, 8'h0F, 8'h0E};
`endif
    c_load = 1'b1; c_count = 8'h10; c_en = 1'b0;
    step();
    c_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({hi_a, lo_a} !== exp_v[i]) begin
        n_fail++;
        $display("FAIL cascade%0d val=%h exp=%h",
                 i, {hi_a, lo_a}, exp_v[i]);
      end
      c_en = 1'b1;
      step();
    end
    c_en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    count   = 4'd0;
    c_en    = 1'b0;
    c_load  = 1'b0;
    c_count = 8'h00;
    #12;
    test_reset();
    test_countout();
    test_load_priority();
    test_hold();
    test_underflow();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
